pipeline_accum: RTL

PIPELINE_ACCUM -- requirements
Module: pipeline_accum

---
 rtl/pipeline_accum_if.sv | 35 +++
 rtl/pipeline_accum.sv | 112 +++++++++++
 2 files changed

// File: rtl/pipeline_accum_if.sv
// Handshake bundle for pipeline_accum: product input stream, frame abort,
// and frame-sum output stream. The upstream/bench side uses the master
// modport and the accumulator uses the slave modport.
interface pipeline_accum_if;
  logic [15:0] D;
  logic        in_valid;
  logic        in_ready;
  logic        clr;
  logic [17:0] sum;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output D,
    output in_valid,
    output clr,
    output out_ready,
    input  in_ready,
    input  sum,
    input  ovf,
    input  out_valid
  );

  modport slave (
    input  D,
    input  in_valid,
    input  clr,
    input  out_ready,
    output in_ready,
    output sum,
    output ovf,
    output out_valid
  );
endinterface

// File: rtl/pipeline_accum.sv
// pipeline_accum: sums LEN unsigned 16-bit products per frame into an
// 18-bit result with overflow flag, under valid/ready handshakes on both
// sides. Two states: ACC collects beats, DONE holds the result until the
// downstream takes it.
//
// Build option: define ACCUM_SAT_EN to make the accumulator clamp at
// 18'h3FFFF on overflow; otherwise it wraps modulo 2^18. The ovf flag
// behaves the same in both builds.
module pipeline_accum #(
  parameter int LEN = 4  // products per frame, 1..16
) (
  input logic            clk,
  input logic            rst,
  pipeline_accum_if.slave bus
);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Counter value on the final beat of a frame.
  localparam logic [3:0] LAST_CNT = 4'(LEN - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [17:0] acc_q;
  logic        ovf_q;
  logic        in_ready_q;
  logic        out_valid_q;

  logic        beat;
  logic        first_beat;
  logic [18:0] sum_wide;
  logic        carry;
  logic [17:0] acc_d;
  logic        ovf_d;

  // Next accumulator and overflow values for a beat accepted this cycle.
  always_comb begin
    beat       = bus.in_valid && in_ready_q;
    first_beat = (cnt_q == 4'd0);
    sum_wide   = {1'b0, acc_q} + {3'b000, bus.D};
    carry      = sum_wide[18];
    acc_d      = sum_wide[17:0];
    ovf_d      = ovf_q;
    if (first_beat) begin
      // A new frame never builds on the previous frame's result.
      acc_d = {2'b00, bus.D};
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q | carry;
`ifdef ACCUM_SAT_EN
      // Once clamped, the accumulator stays pinned for the rest of the frame.
      if (ovf_q || carry) begin
        acc_d = 18'h3FFFF;
      end
`else
      acc_d = sum_wide[17:0];
`endif
    end
  end

  // Frame FSM with registered handshake outputs; rst and clr both abort.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      state_q     <= ACC;
      cnt_q       <= 4'd0;
      acc_q       <= 18'd0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (beat) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            if (cnt_q == LAST_CNT) begin
              cnt_q       <= 4'd0;
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        DONE: begin
          // Result held stable; in_ready stays low on the exit edge so no
          // beat can slip in while the result is being taken.
          if (bus.out_ready) begin
            state_q     <= ACC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ACC;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sum       = acc_q;
  assign bus.ovf       = ovf_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

endmodule
